segment_to_accumulate: RTL and testbench

SEGMENT_TO_ACCUMULATE -- requirements
Module: segment_to_accumulate

---
 rtl/segment_to_accumulate_if.sv | 27 ++
 rtl/segment_to_accumulate.sv | 132 +++++++++++++
 tb/tb_segment_to_accumulate.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/segment_to_accumulate_if.sv
// Upstream segment beats and downstream accumulated-increment beats for segment_to_accumulate.
// slave is the design's view; master is the driving/observing side.
interface segment_to_accumulate_if #(
    parameter int W = 3
);
    logic            s_valid;
    logic            s_ready;
    logic [1:0][6:0] s_data;
    logic            m_valid;
    logic            m_ready;
    logic [W-1:0]    m_data;
    logic [6:0]      m_value;
    logic            m_err;
    logic            m_wrap;

    // Both sides use valid/ready: a beat transfers on a rising edge where valid and
    // ready are both high; valid and its payload hold steady until that edge.
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_value, m_err, m_wrap
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_value, m_err, m_wrap
    );
endinterface

// File: rtl/segment_to_accumulate.sv
// Recovers per-beat increments from a two-digit 7-segment running sum that restarts
// at 0 every N beats; one-entry registered output with a SYNC/LOCKED framing FSM.
module segment_to_accumulate #(
    parameter int N = 10,
    parameter int W = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    segment_to_accumulate_if.slave bus,
    output logic                   locked
);
    localparam int              CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [6:0]      MAX_INC = 7'((1 << W) - 1);
    localparam logic [CW-1:0]   LAST    = CW'(N - 1);

    typedef enum logic {SYNC = 1'b0, LOCKED = 1'b1} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [6:0]      r_prev;
    logic            r_m_valid;
    logic [W-1:0]    r_m_data;
    logic [6:0]      r_m_value;
    logic            r_m_err;
    logic            r_m_wrap;

    logic [4:0]      w_tens;
    logic [4:0]      w_units;
    logic            w_bad;
    logic [6:0]      w_value;
    logic [6:0]      w_diff;
    logic [CW-1:0]   w_cnt_next;
    logic            w_accept;

    // Returns {code_ok, digit}.
    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        case (code)
            7'h7E:   seg_decode = {1'b1, 4'd0};
            7'h30:   seg_decode = {1'b1, 4'd1};
            7'h6D:   seg_decode = {1'b1, 4'd2};
            7'h79:   seg_decode = {1'b1, 4'd3};
            7'h33:   seg_decode = {1'b1, 4'd4};
            7'h5B:   seg_decode = {1'b1, 4'd5};
            7'h5F:   seg_decode = {1'b1, 4'd6};
            7'h70:   seg_decode = {1'b1, 4'd7};
            7'h7F:   seg_decode = {1'b1, 4'd8};
            7'h7B:   seg_decode = {1'b1, 4'd9};
            default: seg_decode = 5'd0;
        endcase
    endfunction

    always_comb begin
        w_tens     = seg_decode(bus.s_data[1]);
        w_units    = seg_decode(bus.s_data[0]);
        w_bad      = !(w_tens[4] && w_units[4]);
        w_value    = w_bad ? 7'd0 : (7'(w_tens[3:0]) * 7'd10 + 7'(w_units[3:0]));
        w_diff     = w_value - r_prev;
        w_cnt_next = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end

    assign bus.s_ready = !r_m_valid || bus.m_ready;
    assign w_accept    = bus.s_valid && bus.s_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= SYNC;
            r_cnt     <= '0;
            r_prev    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_value <= '0;
            r_m_err   <= 1'b0;
            r_m_wrap  <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                SYNC: begin
                    if (!w_bad && (w_value == 7'd0)) begin
                        r_state   <= LOCKED;
                        r_cnt     <= CW'(1);
                        r_prev    <= '0;
                        r_m_valid <= 1'b1;
                        r_m_data  <= '0;
                        r_m_value <= '0;
                        r_m_err   <= 1'b0;
                        r_m_wrap  <= 1'b0;
                    end else begin
                        r_m_valid <= 1'b0;
                    end
                end
                LOCKED: begin
                    r_m_valid <= 1'b1;
                    r_m_value <= w_value;
                    r_m_data  <= '0;
                    r_m_err   <= 1'b0;
                    r_m_wrap  <= 1'b0;
                    r_cnt     <= w_cnt_next;
                    // An unreadable beat still occupies a window slot but tells us nothing about the sum.
                    if (w_bad) begin
                        r_m_err <= 1'b1;
                    end else if (r_cnt == '0) begin
                        if (w_value != 7'd0) begin
                            r_m_err <= 1'b1;
                            r_state <= SYNC;
                            r_cnt   <= '0;
                        end else begin
                            r_prev <= '0;
                        end
                    end else if (w_value >= r_prev) begin
                        r_prev <= w_value;
                        if (w_diff <= MAX_INC) r_m_data <= w_diff[W-1:0];
                        else                   r_m_err  <= 1'b1;
                    end else begin
                        r_m_wrap <= 1'b1;
                        r_prev   <= w_value;
                        if (w_value <= MAX_INC) r_m_data <= w_value[W-1:0];
                        else                    r_m_err  <= 1'b1;
                    end
                end
                default: r_state <= SYNC;
            endcase
        end else if (bus.m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_value = r_m_value;
    assign bus.m_err   = r_m_err;
    assign bus.m_wrap  = r_m_wrap;
    assign locked      = (r_state == LOCKED);
endmodule

// File: tb/tb_segment_to_accumulate.sv
// Directed scenarios plus randomized beats checked against a window/prev reference model.
module tb_segment_to_accumulate;
    localparam int N = 10;
    localparam int W = 3;

    logic clk;
    logic rstn;
    logic locked;
    int   n_checks;
    int   n_fail;

    // Reference model state: lock flag, beat position inside the window, previous sum.
    int   ml;
    int   mpos;
    int   mprev;
    logic [W+9:0] exp_q[$];

    segment_to_accumulate_if #(.W(W)) bus();

    segment_to_accumulate #(.N(N), .W(W)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bus),
        .locked (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got still running, want finished");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'h7E; 1: seg = 7'h30; 2: seg = 7'h6D; 3: seg = 7'h79; 4: seg = 7'h33;
            5: seg = 7'h5B; 6: seg = 7'h5F; 7: seg = 7'h70; 8: seg = 7'h7F; default: seg = 7'h7B;
        endcase
    endfunction

    function automatic logic [13:0] enc(input int v);
        return {seg(v / 10), seg(v % 10)};
    endfunction

    // Called at a falling edge; returns at the falling edge after the beat was accepted.
    task automatic beat(input logic [13:0] d);
        int t;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        #1;
        t = 0;
        while (!bus.s_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: got s_ready=%b, want 1", bus.s_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #2;
        @(negedge clk);
        rstn = 1'b1;
        ml = 0; mpos = 0; mprev = 0;
    endtask

    task automatic model_step(input int v, input bit bad);
        bit emit, err, wrap;
        int data, ev;
        emit = 0; err = 0; wrap = 0; data = 0;
        ev = bad ? 0 : v;
        if (ml == 0) begin
            if (!bad && v == 0) begin
                emit = 1; ml = 1; mpos = 1; mprev = 0;
            end
        end else begin
            emit = 1;
            if (bad) err = 1;
            else if (mpos == 0) begin
                if (v != 0) begin err = 1; ml = 0; end
                else mprev = 0;
            end else if (v >= mprev) begin
                if (v - mprev < 2 ** W) data = v - mprev; else err = 1;
                mprev = v;
            end else begin
                wrap = 1;
                if (v < 2 ** W) data = v; else err = 1;
                mprev = v;
            end
            mpos = (ml != 0) ? (mpos + 1) % N : 0;
        end
        exp_q.push_back({emit, err, wrap, 7'(ev), W'(data)});
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        #1;
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
        n_checks++; if (bus.m_data !== '0) begin n_fail++; $display("FAIL rst_m_data: got %0d want 0", bus.m_data); end
        n_checks++; if (bus.m_value !== 7'd0) begin n_fail++; $display("FAIL rst_m_value: got %0d want 0", bus.m_value); end
        n_checks++; if ({bus.m_err, bus.m_wrap} !== 2'b00) begin n_fail++; $display("FAIL rst_err_wrap: got %b want 00", {bus.m_err, bus.m_wrap}); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b want 0", locked); end
        n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready: got %b want 1", bus.s_ready); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_sync();
        beat(enc(10));
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL sync_ten_valid: got %b want 0", bus.m_valid); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL sync_ten_locked: got %b want 0", locked); end
        beat(enc(0));
        n_checks++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL sync_zero_valid: got %b want 1", bus.m_valid); end
        n_checks++; if (bus.m_value !== 7'd0 || bus.m_data !== '0) begin n_fail++; $display("FAIL sync_zero_out: got value=%0d data=%0d want 0/0", bus.m_value, bus.m_data); end
        n_checks++; if (bus.m_err !== 1'b0) begin n_fail++; $display("FAIL sync_zero_err: got %b want 0", bus.m_err); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sync_zero_locked: got %b want 1", locked); end
    endtask

    task automatic test_window();
        int sums[10] = '{0, 3, 5, 12, 14, 15, 20, 22, 27, 30};
        for (int i = 1; i < 10; i++) begin
            beat(enc(sums[i]));
            n_checks++; if (bus.m_valid !== 1'b1 || bus.m_err !== 1'b0 || bus.m_wrap !== 1'b0) begin n_fail++; $display("FAIL win_flags beat%0d: got v/e/w=%b%b%b want 100", i, bus.m_valid, bus.m_err, bus.m_wrap); end
            n_checks++; if (bus.m_data !== W'(sums[i] - sums[i-1])) begin n_fail++; $display("FAIL win_data beat%0d: got %0d want %0d", i, bus.m_data, sums[i] - sums[i-1]); end
            n_checks++; if (bus.m_value !== 7'(sums[i])) begin n_fail++; $display("FAIL win_value beat%0d: got %0d want %0d", i, bus.m_value, sums[i]); end
        end
        beat(enc(0));
        n_checks++; if (bus.m_valid !== 1'b1 || bus.m_err !== 1'b0 || bus.m_data !== '0) begin n_fail++; $display("FAIL win_restart: got v/e/d=%b%b%0d want 1/0/0", bus.m_valid, bus.m_err, bus.m_data); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL win_restart_locked: got %b want 1", locked); end
    endtask

    task automatic test_overflow();
        beat(enc(97));
        n_checks++; if (bus.m_err !== 1'b1 || bus.m_value !== 7'd97) begin n_fail++; $display("FAIL ovf_big_inc: got err=%b value=%0d want 1/97", bus.m_err, bus.m_value); end
        beat(enc(4));
        n_checks++; if (bus.m_wrap !== 1'b1 || bus.m_err !== 1'b0 || bus.m_data !== W'(4)) begin n_fail++; $display("FAIL ovf_wrap4: got wrap=%b err=%b data=%0d want 1/0/4", bus.m_wrap, bus.m_err, bus.m_data); end
        beat(enc(97));
        beat(enc(12));
        n_checks++; if (bus.m_wrap !== 1'b1 || bus.m_err !== 1'b1 || bus.m_data !== '0) begin n_fail++; $display("FAIL ovf_wrap12: got wrap=%b err=%b data=%0d want 1/1/0", bus.m_wrap, bus.m_err, bus.m_data); end
        n_checks++; if (bus.m_value !== 7'd12) begin n_fail++; $display("FAIL ovf_wrap12_value: got %0d want 12", bus.m_value); end
    endtask

    task automatic test_bad_code();
        beat({7'h30, 7'h00});
        n_checks++; if (bus.m_err !== 1'b1 || bus.m_data !== '0 || bus.m_value !== 7'd0) begin n_fail++; $display("FAIL bad_code: got err=%b data=%0d value=%0d want 1/0/0", bus.m_err, bus.m_data, bus.m_value); end
        beat(enc(15));
        n_checks++; if (bus.m_err !== 1'b0 || bus.m_data !== W'(3)) begin n_fail++; $display("FAIL bad_prev_kept: got err=%b data=%0d want 0/3", bus.m_err, bus.m_data); end
        beat(enc(16));
        beat(enc(17));
        beat(enc(18));
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL bad_still_locked: got %b want 1", locked); end
        beat(enc(5));
        n_checks++; if (bus.m_err !== 1'b1 || bus.m_data !== '0 || locked !== 1'b0) begin n_fail++; $display("FAIL lost_sync: got err=%b data=%0d locked=%b want 1/0/0", bus.m_err, bus.m_data, locked); end
        beat(enc(5));
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL lost_sync_drop: got m_valid=%b want 0", bus.m_valid); end
        beat(enc(0));
        n_checks++; if (bus.m_valid !== 1'b1 || locked !== 1'b1) begin n_fail++; $display("FAIL relock: got valid=%b locked=%b want 1/1", bus.m_valid, locked); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.m_ready = 1'b0;
        beat(enc(2));
        bus.s_valid = 1'b1;
        bus.s_data  = enc(5);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready cyc%0d: got %b want 0", k, bus.s_ready); end
            n_checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== W'(2) || bus.m_value !== 7'd2) begin n_fail++; $display("FAIL bp_hold cyc%0d: got v=%b d=%0d val=%0d want 1/2/2", k, bus.m_valid, bus.m_data, bus.m_value); end
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        #1;
        n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got s_ready=%b want 1", bus.s_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        n_checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== W'(3) || bus.m_value !== 7'd5) begin n_fail++; $display("FAIL bp_next: got v=%b d=%0d val=%0d want 1/3/5", bus.m_valid, bus.m_data, bus.m_value); end
        @(negedge clk);
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got m_valid=%b want 0", bus.m_valid); end
    endtask

    task automatic test_reset_mid();
        bus.m_ready = 1'b0;
        beat(enc(7));
        rstn = 1'b0;
        #1;
        n_checks++; if (bus.m_valid !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL rmid_drop: got valid=%b locked=%b want 0/0", bus.m_valid, locked); end
        n_checks++; if (bus.s_ready !== 1'b1 || bus.m_value !== 7'd0) begin n_fail++; $display("FAIL rmid_regs: got s_ready=%b value=%0d want 1/0", bus.s_ready, bus.m_value); end
        @(negedge clk);
        rstn = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_partial: got m_valid=%b want 0", bus.m_valid); end
        beat(enc(8));
        n_checks++; if (bus.m_valid !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL rmid_needs_sync: got valid=%b locked=%b want 0/0", bus.m_valid, locked); end
        beat(enc(0));
        n_checks++; if (bus.m_valid !== 1'b1 || locked !== 1'b1) begin n_fail++; $display("FAIL rmid_resync: got valid=%b locked=%b want 1/1", bus.m_valid, locked); end
    endtask

    task automatic test_random();
        logic [W+9:0] e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int v;
            bit bad;
            bad = 0;
            if (ml == 0) v = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 99);
            else if (mpos == 0) v = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 99) : 0;
            else begin
                case ($urandom_range(0, 9))
                    0: begin bad = 1; v = 0; end
                    1: v = $urandom_range(0, 99);
                    default: begin
                        v = mprev + $urandom_range(0, 8);
                        if (v > 99) v = 99;
                    end
                endcase
            end
            model_step(v, bad);
            beat(bad ? {seg(v / 10), 7'h00} : enc(v));
            e = exp_q.pop_front();
            n_checks++; if (bus.m_valid !== e[W+9]) begin n_fail++; $display("FAIL rnd_valid #%0d: got %b want %b", i, bus.m_valid, e[W+9]); end
            if (e[W+9]) begin
                n_checks++; if ({bus.m_err, bus.m_wrap, bus.m_value, bus.m_data} !== e[W+8:0]) begin n_fail++; $display("FAIL rnd_out #%0d: got err=%b wrap=%b val=%0d data=%0d want err=%b wrap=%b val=%0d data=%0d", i, bus.m_err, bus.m_wrap, bus.m_value, bus.m_data, e[W+8], e[W+7], e[W+6:W], e[W-1:0]); end
            end
            n_checks++; if (locked !== (ml != 0)) begin n_fail++; $display("FAIL rnd_locked #%0d: got %b want %0d", i, locked, ml); end
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        ml = 0; mpos = 0; mprev = 0;
        rstn = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b1;
        test_reset();
        test_sync();
        test_window();
        test_overflow();
        test_bad_code();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
